// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: breakout game-flow sequencer (idle/serve/play/lost/over/win).
// Define GAME_FLOW_PAUSE_EN to compile in the PAUSE state and key_pause_n handling.
module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 120,
    parameter int LOST_FRAMES  = 60,
    parameter int CORE_RST_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_left_n,
    input  logic        key_right_n,
    input  logic        key_pause_n,
    input  logic        vsync,
    input  logic        hit_tgl,
    input  logic        ball_lost,
    input  logic        cleared,
    output logic        core_rst_n,
    output logic        game_run,
    output logic        ball_hold,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        end_game,
    output logic        win,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_LOST  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;
`ifdef GAME_FLOW_PAUSE_EN
    localparam logic [2:0] S_PAUSE = 3'd6;
`endif
    localparam int RC_W = $clog2(CORE_RST_CYC) + 1;

    logic [1:0]      vs_s, ht_s, bl_s, cl_s;
    logic            vs_q, ht_q;
    logic [1:0]      kl_q, kr_q;
    logic            frame_tick, hit_ev, lost_s, clr_s;
    logic            press_left, press_right, press_any;
    logic [RC_W-1:0] rc_cnt;
    logic            core_rst_req;
    logic [2:0]      st_nxt;
    logic [1:0]      lives_nxt;
    logic [15:0]     score_nxt;
    logic [7:0]      fc, fc_nxt;

    // two-flop synchronisers for the vga_clk-domain core signals
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_s <= '0;
            ht_s <= '0;
            bl_s <= '0;
            cl_s <= '0;
            vs_q <= 1'b0;
            ht_q <= 1'b0;
        end else begin
            vs_s <= {vs_s[0], vsync};
            ht_s <= {ht_s[0], hit_tgl};
            bl_s <= {bl_s[0], ball_lost};
            cl_s <= {cl_s[0], cleared};
            vs_q <= vs_s[1];
            ht_q <= ht_s[1];
        end
    end

    assign frame_tick = vs_s[1] & ~vs_q;
    assign hit_ev     = ht_s[1] ^ ht_q;
    assign lost_s     = bl_s[1];
    assign clr_s      = cl_s[1];

    // register key levels so a press is a single-cycle falling-edge pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            kl_q <= 2'b11;
            kr_q <= 2'b11;
        end else begin
            kl_q <= {kl_q[0], key_left_n};
            kr_q <= {kr_q[0], key_right_n};
        end
    end

    assign press_left  = kl_q[1] & ~kl_q[0];
    assign press_right = kr_q[1] & ~kr_q[0];
    assign press_any   = press_left | press_right;

`ifdef GAME_FLOW_PAUSE_EN
    logic [1:0] kp_q;
    logic       press_pause;

    // pause key edge detector, same shape as the paddle keys
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) kp_q <= 2'b11;
        else            kp_q <= {kp_q[0], key_pause_n};
    end

    assign press_pause = kp_q[1] & ~kp_q[0];
`else
    logic unused_pause;
    assign unused_pause = key_pause_n;
`endif

    // stretch each core reset request to CORE_RST_CYC cycles low
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            core_rst_n <= 1'b0;
            rc_cnt     <= RC_W'(CORE_RST_CYC - 1);
        end else if (core_rst_req) begin
            core_rst_n <= 1'b0;
            rc_cnt     <= RC_W'(CORE_RST_CYC - 1);
        end else if (rc_cnt != '0) begin
            rc_cnt <= rc_cnt - RC_W'(1);
        end else begin
            core_rst_n <= 1'b1;
        end
    end

    // next-state, lives, score and frame-count decisions
    always_comb begin
        st_nxt       = state;
        lives_nxt    = lives;
        score_nxt    = score;
        fc_nxt       = frame_tick ? fc + 8'd1 : fc;
        core_rst_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_any) begin
                    core_rst_req = 1'b1;
                    lives_nxt    = 2'(LIVES);
                    score_nxt    = '0;
                    st_nxt       = S_SERVE;
                end
            end
            S_SERVE: begin
                if (press_any ||
                    (frame_tick && fc == 8'(SERVE_FRAMES - 1)))
                    st_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (hit_ev && score != 16'hFFFF)
                    score_nxt = score + 16'd1;
                if (clr_s) begin
                    st_nxt = S_WIN;
                end else if (lost_s) begin
                    lives_nxt = lives - 2'd1;
                    st_nxt    = S_LOST;
`ifdef GAME_FLOW_PAUSE_EN
                end else if (press_pause) begin
                    st_nxt = S_PAUSE;
`endif
                end
            end
            S_LOST: begin
                if (frame_tick && fc == 8'(LOST_FRAMES - 1))
                    st_nxt = (lives == 2'd0) ? S_OVER : S_SERVE;
            end
            S_OVER, S_WIN: begin
                if (press_any) begin
                    core_rst_req = 1'b1;
                    st_nxt       = S_IDLE;
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            S_PAUSE: begin
                if (press_pause) st_nxt = S_PLAY;
            end
`endif
            default: st_nxt = S_IDLE;
        endcase
        if (st_nxt != state) fc_nxt = '0;
    end

    // state and all outputs registered, outputs decoded from the next state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            lives     <= '0;
            score     <= '0;
            fc        <= '0;
            game_run  <= 1'b0;
            ball_hold <= 1'b1;
            end_game  <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= st_nxt;
            lives     <= lives_nxt;
            score     <= score_nxt;
            fc        <= fc_nxt;
            game_run  <= (st_nxt == S_SERVE) || (st_nxt == S_PLAY);
            ball_hold <= (st_nxt == S_IDLE) || (st_nxt == S_SERVE);
            end_game  <= (st_nxt == S_OVER);
            win       <= (st_nxt == S_WIN);
        end
    end

    // PLAY is never entered with zero lives, so a loss there cannot underflow
    a_no_underflow: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (state == S_PLAY && lost_s && !clr_s) |-> (lives != 2'd0));

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed vector table, hand sequences and random
// transactions checked against an event-level game model.
module tb_game_flow_ctrl;

    localparam int N_LIVES = 3;
    localparam int N_SERVE = 120;
    localparam int N_LOST  = 60;

    localparam int ST_IDLE  = 0;
    localparam int ST_SERVE = 1;
    localparam int ST_PLAY  = 2;
    localparam int ST_LOST  = 3;
    localparam int ST_OVER  = 4;
    localparam int ST_WIN   = 5;
    localparam int ST_PAUSE = 6;

`ifdef GAME_FLOW_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int A_PRESS  = 0;
    localparam int A_FRAMES = 1;
    localparam int A_HITS   = 2;
    localparam int A_LOST   = 3;
    localparam int A_CLEAR  = 4;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_PAUSE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kl = 1'b1, kr = 1'b1, kp = 1'b1;
    logic        vs = 1'b0, ht = 1'b0, bl = 1'b0, cl = 1'b0;
    logic        core_rst_n, game_run, ball_hold, end_game, win;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [2:0]  state;

    game_flow_ctrl dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key_left_n  (kl),
        .key_right_n (kr),
        .key_pause_n (kp),
        .vsync       (vs),
        .hit_tgl     (ht),
        .ball_lost   (bl),
        .cleared     (cl),
        .core_rst_n  (core_rst_n),
        .game_run    (game_run),
        .ball_hold   (ball_hold),
        .lives       (lives),
        .score       (score),
        .end_game    (end_game),
        .win         (win),
        .state       (state)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_st    = ST_IDLE;
    int m_lives = 0;
    int m_score = 0;
    int m_fc    = 0;

    typedef struct {
        int act; int arg;
        int st; int lv; int sc; int run; int hold; int eg; int wn;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void m_enter(input int s);
        m_st = s;
        m_fc = 0;
    endfunction

    function automatic void m_press(input int k);
        bit any;
        any = (k != K_PAUSE);
        case (m_st)
            ST_IDLE: if (any) begin
                m_lives = N_LIVES;
                m_score = 0;
                m_enter(ST_SERVE);
            end
            ST_SERVE: if (any) m_enter(ST_PLAY);
            ST_PLAY:  if (k == K_PAUSE && PAUSE_EN) m_enter(ST_PAUSE);
            ST_PAUSE: if (k == K_PAUSE) m_enter(ST_PLAY);
            ST_OVER, ST_WIN: if (any) m_enter(ST_IDLE);
            default: ;
        endcase
    endfunction

    function automatic void m_frame();
        m_fc++;
        if (m_st == ST_SERVE && m_fc == N_SERVE)
            m_enter(ST_PLAY);
        else if (m_st == ST_LOST && m_fc == N_LOST)
            m_enter(m_lives == 0 ? ST_OVER : ST_SERVE);
    endfunction

    function automatic void m_hit();
        if (m_st == ST_PLAY && m_score < 65535) m_score++;
    endfunction

    function automatic void m_lost(input bit c);
        if (m_st == ST_PLAY) begin
            if (c) m_enter(ST_WIN);
            else begin
                m_lives--;
                m_enter(ST_LOST);
            end
        end
    endfunction

    function automatic void m_clear();
        if (m_st == ST_PLAY) m_enter(ST_WIN);
    endfunction

    task automatic do_act(input int act, input int arg);
        case (act)
            A_PRESS: begin
                if (arg == K_LEFT) kl = 1'b0;
                else if (arg == K_RIGHT) kr = 1'b0;
                else kp = 1'b0;
                cyc(4);
                kl = 1'b1; kr = 1'b1; kp = 1'b1;
                cyc(2);
                m_press(arg);
            end
            A_FRAMES: for (int i = 0; i < arg; i++) begin
                vs = 1'b1; cyc(3);
                vs = 1'b0; cyc(3);
                m_frame();
            end
            A_HITS: for (int i = 0; i < arg; i++) begin
                ht = ~ht; cyc(4);
                m_hit();
            end
            A_LOST: begin
                bl = 1'b1; cl = (arg != 0);
                cyc(4);
                bl = 1'b0; cl = 1'b0;
                cyc(4);
                m_lost(arg != 0);
            end
            default: begin
                cl = 1'b1; cyc(4);
                cl = 1'b0; cyc(4);
                m_clear();
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(state), m_st);
        chk({tag, ".lives"}, int'(lives), m_lives);
        chk({tag, ".score"}, int'(score), m_score);
        chk({tag, ".run"}, int'(game_run),
            (m_st == ST_SERVE || m_st == ST_PLAY) ? 1 : 0);
        chk({tag, ".end"}, int'(end_game), (m_st == ST_OVER) ? 1 : 0);
        chk({tag, ".win"}, int'(win), (m_st == ST_WIN) ? 1 : 0);
        if (m_st == ST_IDLE || m_st == ST_SERVE)
            chk({tag, ".hold"}, int'(ball_hold), 1);
        else if (m_st == ST_PLAY || m_st == ST_PAUSE)
            chk({tag, ".hold"}, int'(ball_hold), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{A_PRESS,  K_LEFT,  1, 3, 0, 1,  1, 0, 0},
            '{A_FRAMES, 119,     1, 3, 0, 1,  1, 0, 0},
            '{A_FRAMES, 1,       2, 3, 0, 1,  0, 0, 0},
            '{A_HITS,   5,       2, 3, 5, 1,  0, 0, 0},
            '{A_LOST,   0,       3, 2, 5, 0, -1, 0, 0},
            '{A_FRAMES, 59,      3, 2, 5, 0, -1, 0, 0},
            '{A_FRAMES, 1,       1, 2, 5, 1,  1, 0, 0},
            '{A_PRESS,  K_RIGHT, 2, 2, 5, 1,  0, 0, 0},
            '{A_HITS,   2,       2, 2, 7, 1,  0, 0, 0},
            '{A_LOST,   0,       3, 1, 7, 0, -1, 0, 0},
            '{A_FRAMES, 60,      1, 1, 7, 1,  1, 0, 0},
            '{A_FRAMES, 120,     2, 1, 7, 1,  0, 0, 0},
            '{A_LOST,   0,       3, 0, 7, 0, -1, 0, 0},
            '{A_FRAMES, 60,      4, 0, 7, 0, -1, 1, 0},
            '{A_HITS,   1,       4, 0, 7, 0, -1, 1, 0},
            '{A_PRESS,  K_LEFT,  0, 0, 7, 0,  1, 0, 0},
            '{A_PRESS,  K_RIGHT, 1, 3, 0, 1,  1, 0, 0},
            '{A_PRESS,  K_LEFT,  2, 3, 0, 1,  0, 0, 0},
            '{A_LOST,   1,       5, 3, 0, 0, -1, 0, 1},
            '{A_PRESS,  K_LEFT,  0, 3, 0, 0,  1, 0, 0}
        };

        // reset: core reset held, then released 4 cycles after deassertion
        cyc(3);
        chk("rst.core_rst_n", int'(core_rst_n), 0);
        chk("rst.hold", int'(ball_hold), 1);
        check_all("rst");
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst.core_rst_n.c%0d", i), int'(core_rst_n),
                (i >= 4) ? 1 : 0);
        end

        for (int i = 0; i < 20; i++) begin
            do_act(tbl[i].act, tbl[i].arg);
            chk($sformatf("v%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("v%0d.lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("v%0d.score", i), int'(score), tbl[i].sc);
            chk($sformatf("v%0d.run", i), int'(game_run), tbl[i].run);
            chk($sformatf("v%0d.end", i), int'(end_game), tbl[i].eg);
            chk($sformatf("v%0d.win", i), int'(win), tbl[i].wn);
            if (tbl[i].hold >= 0)
                chk($sformatf("v%0d.hold", i), int'(ball_hold), tbl[i].hold);
        end

        // key latency and core reset pulse placement from IDLE
        kl = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("key.state.c%0d", i), int'(state),
                (i >= 2) ? ST_SERVE : ST_IDLE);
            chk($sformatf("key.core_rst_n.c%0d", i), int'(core_rst_n),
                (i >= 2 && i <= 5) ? 0 : 1);
            if (i == 4) kl = 1'b1;
        end
        m_press(K_LEFT);
        check_all("key");

        // hit on the same cycle PLAY is left still counts
        do_act(A_PRESS, K_RIGHT);
        ht = ~ht; bl = 1'b1;
        cyc(4);
        bl = 1'b0;
        cyc(4);
        m_hit();
        m_lost(1'b0);
        check_all("hitexit");
        chk("hitexit.score", int'(score), 1);
        do_act(A_FRAMES, N_LOST);
        do_act(A_PRESS, K_LEFT);
        check_all("replay");

        // pause press, hits while paused, pause press again
        do_act(A_PRESS, K_PAUSE);
        check_all("pause1");
        do_act(A_HITS, 2);
        check_all("pause.hits");
        do_act(A_PRESS, K_PAUSE);
        check_all("pause2");

        // score saturation
        force dut.score = 16'hFFFE;
        cyc(1);
        release dut.score;
        cyc(1);
        m_score = 16'hFFFE;
        chk("sat.preload", int'(score), 16'hFFFE);
        do_act(A_HITS, 1);
        check_all("sat1");
        do_act(A_HITS, 1);
        check_all("sat2");
        chk("sat.hold", int'(score), 16'hFFFF);

        // random transactions against the model
        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 30)
                do_act(A_PRESS, int'($urandom_range(0, 2)));
            else if (r < 50)
                do_act(A_FRAMES, int'($urandom_range(1, 40)));
            else if (r < 70)
                do_act(A_HITS, int'($urandom_range(1, 3)));
            else if (r < 85)
                do_act(A_LOST, ($urandom_range(0, 3) == 0) ? 1 : 0);
            else
                do_act(A_CLEAR, 0);
            check_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
